// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcodes, FSM states,
// port ids and the round-robin pick function.
package alu_arbiter_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_ADDU = 3'd2;
  localparam logic [2:0] OP_SUBU = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_LUI  = 3'd7;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Round-robin pick: the priority holder wins a tie, a lone requester always wins.
  function automatic logic pick_port(input logic v0, input logic v1, input logic prio);
    logic g;
    if (v0 && v1) begin
      g = prio;
    end else if (v1) begin
      g = PORT1;
    end else begin
      g = PORT0;
    end
    return g;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and the arbiter.
interface alu_arbiter_if #(parameter int CNT_W = 16) ();
  import alu_arbiter_pkg::*;

  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [3:0]       req0_aluc;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [3:0]       req1_aluc;
  logic             rsp0_valid, rsp0_ready;
  logic             rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] r;
  logic             zero;
  logic             overflow;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport master (
    output req0_valid, req0_a, req0_b, req0_aluc, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_aluc, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  r, zero, overflow, busy, op_count
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_aluc, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_aluc, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output r, zero, overflow, busy, op_count
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Shared 32-bit combinational ALU; bit 32 of the internal result is carry/borrow.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic [WIDTH-1:0] r,
  output logic             carry
);

  logic [2:0]     op_s;
  logic [WIDTH:0] res_s;

  // Decode opcode (upper-half codes alias to addu) and evaluate the 33-bit result.
  always_comb begin
    op_s  = aluc[3] ? OP_ADDU : aluc[2:0];
    res_s = 33'd0;
    case (op_s)
      OP_ADD, OP_ADDU: res_s = {1'b0, a} + {1'b0, b};
      OP_SUB, OP_SUBU: res_s = {1'b0, a} - {1'b0, b};
      OP_AND:          res_s = {1'b0, a & b};
      OP_OR:           res_s = {1'b0, a | b};
      OP_XOR:          res_s = {1'b0, a ^ b};
      OP_LUI:          res_s = {1'b0, b[15:0], 16'h0000};
      default:         res_s = 33'd0;
    endcase
  end

  assign r     = res_s[WIDTH-1:0];
  assign carry = res_s[WIDTH];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one op in flight.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       aluc_q, aluc_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             any_valid_s;
  logic             pick_s;
  logic             rsp_fire_s;
  logic [WIDTH-1:0] alu_r_s;
  logic             alu_c_s;

  alu_arbiter_alu u_alu (
    .a     (a_q),
    .b     (b_q),
    .aluc  (aluc_q),
    .r     (alu_r_s),
    .carry (alu_c_s)
  );

  assign any_valid_s = bus.req0_valid | bus.req1_valid;
  assign pick_s      = pick_port(bus.req0_valid, bus.req1_valid, prio_q);

  // Ready is only offered in IDLE and only to the port that wins arbitration.
  assign bus.req0_ready = (state_q == ST_IDLE) && any_valid_s && (pick_s == PORT0);
  assign bus.req1_ready = (state_q == ST_IDLE) && any_valid_s && (pick_s == PORT1);

  // Next-state logic: accept in IDLE, capture ALU result in EXEC, hand off in RESP.
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    gnt_d        = gnt_q;
    a_d          = a_q;
    b_d          = b_q;
    aluc_d       = aluc_q;
    r_d          = r_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    rsp_fire_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid_s) begin
          gnt_d   = pick_s;
          a_d     = (pick_s == PORT1) ? bus.req1_a    : bus.req0_a;
          b_d     = (pick_s == PORT1) ? bus.req1_b    : bus.req0_b;
          aluc_d  = (pick_s == PORT1) ? bus.req1_aluc : bus.req0_aluc;
          busy_d  = 1'b1;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        r_d          = alu_r_s;
        zero_d       = (alu_r_s == 32'd0);
        ovf_d        = alu_c_s;
        rsp0_valid_d = (gnt_q == PORT0);
        rsp1_valid_d = (gnt_q == PORT1);
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        rsp_fire_s = (gnt_q == PORT1) ? bus.rsp1_ready : bus.rsp0_ready;
        if (rsp_fire_s) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          busy_d       = 1'b0;
          cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          prio_d       = ~gnt_q;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prio_q       <= PORT0;
      gnt_q        <= PORT0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      aluc_q       <= 4'd0;
      r_q          <= 32'd0;
      zero_q       <= 1'b1;
      ovf_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      gnt_q        <= gnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      aluc_q       <= aluc_d;
      r_q          <= r_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.r          = r_q;
  assign bus.zero       = zero_q;
  assign bus.overflow   = ovf_q;
  assign bus.busy       = busy_q;
  assign bus.op_count   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized + directed bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;

  localparam int CW = 4;

  logic        clk;
  logic        rst_n;
  logic        v[2];
  logic [31:0] a[2];
  logic [31:0] b[2];
  logic [3:0]  op[2];
  logic        rr[2];
  logic        acc[2];

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic        m_busy, m_gnt, m_prio, m_ovf, out_zero, out_ovf;
  int          m_age, m_cnt;
  logic [31:0] m_r, out_r;

  alu_arbiter_if #(.CNT_W(CW)) bus ();

  alu_arbiter #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.req0_valid = v[0];
  assign bus.req0_a     = a[0];
  assign bus.req0_b     = b[0];
  assign bus.req0_aluc  = op[0];
  assign bus.req1_valid = v[1];
  assign bus.req1_a     = a[1];
  assign bus.req1_b     = b[1];
  assign bus.req1_aluc  = op[1];
  assign bus.rsp0_ready = rr[0];
  assign bus.rsp1_ready = rr[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result as defined by the opcode table, computed with plain arithmetic.
  function automatic logic [32:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] code);
    longint unsigned s;
    logic [15:0] lo;
    int k;
    k = code[3] ? 2 : int'(code[2:0]);
    case (k)
      0, 2: begin s = longint'(x) + longint'(y); return s[32:0]; end
      1, 3: return {(x < y), x - y};
      4: return {1'b0, x & y};
      5: return {1'b0, x | y};
      6: return {1'b0, x ^ y};
      default: begin lo = y[15:0]; return {1'b0, lo, 16'h0000}; end
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_gnt = 1'b0; m_prio = 1'b0; m_age = 0; m_cnt = 0;
    m_r = 32'd0; m_ovf = 1'b0; out_r = 32'd0; out_zero = 1'b1; out_ovf = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_rsp0v"}, bus.rsp0_valid, 1'b0);
    check({tag, "_rsp1v"}, bus.rsp1_valid, 1'b0);
    check({tag, "_r"}, bus.r, 32'd0);
    check({tag, "_zero"}, bus.zero, 1'b1);
    check({tag, "_ovf"}, bus.overflow, 1'b0);
    check({tag, "_cnt"}, bus.op_count, 4'd0);
  endtask

  // One clock: inputs already set at a negedge; check ready, advance model, check outputs.
  task automatic cycle();
    logic any, w;
    logic [32:0] res;
    #1;
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    any = v[0] | v[1];
    w = (v[0] && v[1]) ? m_prio : v[1];
    check("req0_ready", bus.req0_ready, !m_busy && any && !w);
    check("req1_ready", bus.req1_ready, !m_busy && any && w);
    if (!m_busy) begin
      if (any) begin
        m_busy = 1'b1; m_gnt = w; m_age = 0; acc[w] = 1'b1;
        res = ref_alu(a[w], b[w], op[w]);
        m_r = res[31:0]; m_ovf = res[32];
      end
    end else if (m_age == 0) begin
      m_age = 1; out_r = m_r; out_zero = (m_r == 32'd0); out_ovf = m_ovf;
    end else if (rr[m_gnt]) begin
      m_busy = 1'b0; m_cnt = (m_cnt + 1) % 16; m_prio = !m_gnt;
    end
    @(negedge clk);
    check("busy", bus.busy, m_busy);
    check("rsp0_valid", bus.rsp0_valid, m_busy && m_age == 1 && m_gnt == 1'b0);
    check("rsp1_valid", bus.rsp1_valid, m_busy && m_age == 1 && m_gnt == 1'b1);
    check("r", bus.r, out_r);
    check("zero", bus.zero, out_zero);
    check("overflow", bus.overflow, out_ovf);
    check("op_count", bus.op_count, m_cnt[3:0]);
  endtask

  task automatic drain();
    int n;
    rr[0] = 1'b1; rr[1] = 1'b1; v[0] = 1'b0; v[1] = 1'b0;
    n = 0;
    while (m_busy && n < 10) begin cycle(); n++; end
    check("drain_timeout", m_busy, 1'b0);
    rr[0] = 1'b0; rr[1] = 1'b0;
  endtask

  // Directed single operation on one port, response held off for 'hold' cycles.
  task automatic do_op(input int p, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [3:0] xop, input int hold, input logic do_exp,
                       input logic [31:0] er, input logic ez, input logic eo);
    int n;
    v[1-p] = 1'b0; rr[0] = 1'b0; rr[1] = 1'b0;
    v[p] = 1'b1; a[p] = xa; b[p] = xb; op[p] = xop;
    acc[p] = 1'b0;
    n = 0;
    while (!acc[p] && n < 8) begin cycle(); n++; end
    check("accept_timeout", acc[p], 1'b1);
    v[p] = 1'b0;
    cycle();
    if (do_exp) begin
      check("dir_rsp_valid", p ? bus.rsp1_valid : bus.rsp0_valid, 1'b1);
      check("dir_r", bus.r, er);
      check("dir_zero", bus.zero, ez);
      check("dir_ovf", bus.overflow, eo);
    end
    for (int i = 0; i < hold; i++) cycle();
    if (do_exp) check("dir_busy_hold", bus.busy, 1'b1);
    drain();
  endtask

  initial begin
    int n, g, prev;
    rst_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      v[p] = 1'b0; a[p] = 32'd0; b[p] = 32'd0; op[p] = 4'd0; rr[p] = 1'b0; acc[p] = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    check("rst_req0_ready", bus.req0_ready, 1'b0);
    rst_n = 1'b1;

    // addu wrap, sub with held response, lui, aluc[3] alias
    do_op(0, 32'hFFFF_FFFF, 32'd1, 4'd2, 0, 1'b1, 32'd0, 1'b1, 1'b1);
    check("op_count_1", bus.op_count, 4'd1);
    do_op(1, 32'd5, 32'd3, 4'd1, 4, 1'b1, 32'd2, 1'b0, 1'b0);
    do_op(0, 32'd0, 32'h0000_1234, 4'd7, 0, 1'b1, 32'h1234_0000, 1'b0, 1'b0);
    do_op(1, 32'd2, 32'd3, 4'b1000, 0, 1'b1, 32'd5, 1'b0, 1'b0);

    // both ports continuously valid: grants must alternate
    v[0] = 1'b1; a[0] = 32'hF0F0_1234; b[0] = 32'h0FF0_FFFF; op[0] = 4'd4;
    v[1] = 1'b1; a[1] = 32'h0000_00F0; b[1] = 32'h0000_0F00; op[1] = 4'd5;
    rr[0] = 1'b1; rr[1] = 1'b1;
    g = 0; prev = -1; n = 0;
    while (g < 8 && n < 60) begin
      cycle();
      n++;
      if (acc[0] || acc[1]) begin
        if (prev >= 0) check("alt_gnt", acc[1], prev == 0);
        prev = acc[1] ? 1 : 0;
        g++;
      end
    end
    check("alt_count", g, 8);
    drain();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (acc[p] || !v[p]) begin
          if ($urandom_range(0, 1) == 1) begin
            v[p] = 1'b1;
            a[p] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            b[p] = ($urandom_range(0, 7) == 0) ? a[p] : $urandom;
            op[p] = 4'($urandom_range(0, 15));
          end else begin
            v[p] = 1'b0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          v[p] = 1'b0;
        end
        rr[p] = ($urandom_range(0, 2) != 0);
      end
      cycle();
    end
    drain();

    // reset during EXEC aborts the operation
    v[0] = 1'b1; a[0] = 32'd7; b[0] = 32'd9; op[0] = 4'd0;
    acc[0] = 1'b0; n = 0;
    while (!acc[0] && n < 8) begin cycle(); n++; end
    check("rst_exec_accept", acc[0], 1'b1);
    v[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rr[0] = 1'b1; rr[1] = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    v[0] = 1'b1; a[0] = 32'd1; b[0] = 32'd1; op[0] = 4'd0;
    v[1] = 1'b1; a[1] = 32'd2; b[1] = 32'd2; op[1] = 4'd0;
    cycle();
    check("post_rst_gnt0", acc[0], 1'b1);
    drain();

    // op_count wraps at 2^CNT_W
    n = 0;
    while (m_cnt != 15 && n < 20) begin
      do_op(n % 2, 32'(n), 32'd1, 4'd6, 0, 1'b0, 32'd0, 1'b0, 1'b0);
      n++;
    end
    check("pre_wrap_cnt", bus.op_count, 4'd15);
    do_op(1, 32'd3, 32'd3, 4'd3, 0, 1'b1, 32'd0, 1'b1, 1'b0);
    check("wrap_cnt", bus.op_count, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
